// File: rtl/can_pkg.sv
// Shared types and constants for the simplified CAN receive path.
package can_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      CRC,
      CRC_DELIM,
      ACK_SLOT,
      ACK_DELIM,
      EOF,
      WAIT_IDLE
   } state_t;

   localparam logic [7:0]  CRC_POLY  = 8'h07;
   localparam int unsigned STUFF_LEN = 5;
   localparam int unsigned EOF_LEN   = 7;
   localparam int unsigned IDLE_LEN  = 11;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_STUFF = 2'b01;
   localparam logic [1:0] ERR_CRC   = 2'b10;
   localparam logic [1:0] ERR_FORM  = 2'b11;

   // One MSB-first CRC-8 step over a single received bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
      crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/can_bit_timing.sv
// Bus-line synchroniser, bit phase counter with hard sync/resync, and sample strobe.
module can_bit_timing #(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned SAMPLE_POINT = CLKS_PER_BIT / 2
) (
   input  logic clk,
   input  logic reset,
   input  logic can_rx,
   input  logic sync_en,
   output logic sample_c,
   output logic rx_bit_c,
   output logic fall_c
);

   localparam int unsigned PW = $clog2(CLKS_PER_BIT);

   logic          sync1;
   logic          sync2;
   logic          rxs_d;
   logic [PW-1:0] phase;

   // Two-flop synchroniser plus one delayed copy for edge detection; idles recessive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= can_rx;
         sync2 <= sync1;
         rxs_d <= sync2;
      end
   end

   assign fall_c   = rxs_d & ~sync2;
   assign rx_bit_c = sync2;
   assign sample_c = (phase == PW'(SAMPLE_POINT));

   // Phase counter; a recessive-to-dominant edge restarts the bit when syncing is allowed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (sync_en && fall_c) begin
         phase <= '0;
      end else if (phase == PW'(CLKS_PER_BIT - 1)) begin
         phase <= '0;
      end else begin
         phase <= phase + PW'(1);
      end
   end

endmodule

// File: rtl/can_receiver.sv
// Simplified CAN frame receiver: destuffing, CRC-8 check, ACK drive and error reporting.
module can_receiver
   import can_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned SAMPLE_POINT = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       can_rx,
   output logic       can_tx,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       rx_err,
   output logic [1:0] err_code
);

   localparam int unsigned RUN_W = 3;
   localparam int unsigned BIT_W = 4;
   localparam int unsigned CNT_W = 4;

   state_t             state;
   logic               sof_pend;
   logic [RUN_W-1:0]   run_cnt;
   logic               run_val;
   logic [BIT_W-1:0]   bit_cnt;
   logic [7:0]         shreg;
   logic [7:0]         crc_calc;
   logic [7:0]         crc_rx;
   logic [CNT_W-1:0]   cnt;

   logic               sample_c;
   logic               rx_bit_c;
   logic               fall_c;
   logic               sync_en;
   logic               stuff_slot_c;
   logic [RUN_W-1:0]   run_next_c;

   assign sync_en = (state == IDLE) || (state == DATA) || (state == CRC);

   can_bit_timing #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .SAMPLE_POINT (SAMPLE_POINT)
   ) u_timing (
      .clk      (clk),
      .reset    (reset),
      .can_rx   (can_rx),
      .sync_en  (sync_en),
      .sample_c (sample_c),
      .rx_bit_c (rx_bit_c),
      .fall_c   (fall_c)
   );

   // The sample after a run of STUFF_LEN equal bits is a stuff bit.
   assign stuff_slot_c = (run_cnt == RUN_W'(STUFF_LEN));
   assign run_next_c   = (rx_bit_c == run_val) ? (run_cnt + RUN_W'(1)) : RUN_W'(1);

   // Frame state machine with destuffer, CRC accumulation and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         sof_pend <= 1'b0;
         run_cnt  <= '0;
         run_val  <= 1'b1;
         bit_cnt  <= '0;
         shreg    <= '0;
         crc_calc <= '0;
         crc_rx   <= '0;
         cnt      <= '0;
         can_tx   <= 1'b1;
         data_out <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (fall_c) begin
                  sof_pend <= 1'b1;
               end else if (sample_c && sof_pend) begin
                  sof_pend <= 1'b0;
                  if (!rx_bit_c) begin
                     state    <= DATA;
                     run_cnt  <= RUN_W'(1);
                     run_val  <= 1'b0;
                     bit_cnt  <= '0;
                     crc_calc <= '0;
                  end
               end
            end
            DATA, CRC: begin
               if (sample_c) begin
                  if (stuff_slot_c) begin
                     if (rx_bit_c == run_val) begin
                        state    <= WAIT_IDLE;
                        cnt      <= '0;
                        rx_err   <= 1'b1;
                        err_code <= ERR_STUFF;
                     end else begin
                        run_cnt <= RUN_W'(1);
                        run_val <= rx_bit_c;
                        if ((state == CRC) && (bit_cnt == BIT_W'(8))) begin
                           state <= CRC_DELIM;
                        end
                     end
                  end else begin
                     run_cnt <= run_next_c;
                     run_val <= rx_bit_c;
                     if (state == DATA) begin
                        shreg    <= {shreg[6:0], rx_bit_c};
                        crc_calc <= crc8_step(crc_calc, rx_bit_c);
                        if (bit_cnt == BIT_W'(7)) begin
                           state   <= CRC;
                           bit_cnt <= '0;
                        end else begin
                           bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                     end else begin
                        crc_rx  <= {crc_rx[6:0], rx_bit_c};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        // A run completed by CRC[0] still owes a stuff bit; stay to check it.
                        if ((bit_cnt == BIT_W'(7)) && (run_next_c != RUN_W'(STUFF_LEN))) begin
                           state <= CRC_DELIM;
                        end
                     end
                  end
               end
            end
            CRC_DELIM: begin
               if (sample_c) begin
                  if (!rx_bit_c) begin
                     state    <= WAIT_IDLE;
                     cnt      <= '0;
                     rx_err   <= 1'b1;
                     err_code <= ERR_FORM;
                  end else if (crc_rx != crc_calc) begin
                     state    <= WAIT_IDLE;
                     cnt      <= '0;
                     rx_err   <= 1'b1;
                     err_code <= ERR_CRC;
                  end else begin
                     state  <= ACK_SLOT;
                     can_tx <= 1'b0;
                  end
               end
            end
            ACK_SLOT: begin
               if (sample_c) begin
                  state  <= ACK_DELIM;
                  can_tx <= 1'b1;
               end
            end
            ACK_DELIM: begin
               if (sample_c) begin
                  if (!rx_bit_c) begin
                     state    <= WAIT_IDLE;
                     cnt      <= '0;
                     rx_err   <= 1'b1;
                     err_code <= ERR_FORM;
                  end else begin
                     state <= EOF;
                     cnt   <= '0;
                  end
               end
            end
            EOF: begin
               if (sample_c) begin
                  if (!rx_bit_c) begin
                     state    <= WAIT_IDLE;
                     cnt      <= '0;
                     rx_err   <= 1'b1;
                     err_code <= ERR_FORM;
                  end else if (cnt == CNT_W'(EOF_LEN - 1)) begin
                     state    <= IDLE;
                     sof_pend <= 1'b0;
                     data_out <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            WAIT_IDLE: begin
               if (sample_c) begin
                  if (!rx_bit_c) begin
                     cnt <= '0;
                  end else if (cnt == CNT_W'(IDLE_LEN - 1)) begin
                     state    <= IDLE;
                     sof_pend <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= WAIT_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/can_receiver.md
Name: can_receiver

Overview:
- Receive side of the team's simplified CAN link; the counterpart of the can_controller transmitter.
- Samples the serial bus line can_rx with a clock-counted bit timer and removes stuff bits.
- Recovers one 8-bit data byte per frame and checks it with CRC-8.
- Drives the ACK slot and reports stuff, CRC and form errors.
- Frame on the wire: SOF(0), D[7:0] MSB-first, CRC[7:0] MSB-first, CRC delimiter(1), ACK slot, ACK delimiter(1), EOF (7×1).
- Stuffing applies from SOF through the last CRC bit.

Parameters:
- CLKS_PER_BIT, 10, clk cycles per bit time; must be at least 4.
- SAMPLE_POINT, CLKS_PER_BIT/2, phase count (0-based) at which a bit is sampled.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- can_rx  input  1  bus line; 1 is recessive, 0 is dominant; asynchronous to clk.
- can_tx  output  1  ACK driver; 0 during the ACK slot of a good frame, otherwise 1.
- data_out  output  8  last correctly received byte; held until the next good frame.
- rx_valid  output  1  one-clk pulse when a complete good frame has been received.
- rx_err  output  1  one-clk pulse when an error is detected.
- err_code  output  2  valid with rx_err: 01 stuff, 10 CRC, 11 form; holds its last value otherwise.

Behaviour:
- Reset is asynchronous and active-low. It applies at any time, including mid-frame.
- Reset values: state=IDLE, can_tx=1, data_out=0, rx_valid=0, rx_err=0, err_code=00, synchroniser flops=1.
- can_rx passes through a 2-flop synchroniser; rxs is its output. All decisions use rxs, adding 2 clk of latency.
- Bit timer: a phase counter runs 0..CLKS_PER_BIT-1 and wraps; a sample strobe fires at phase==SAMPLE_POINT.
  - Hard sync: in IDLE, a 1→0 edge on rxs clears the phase counter.
  - Resync: in DATA or CRC, every 1→0 edge on rxs clears the phase counter.
- State machine (transitions occur on sample strobes):
  - IDLE: on a falling edge, start timing. If the SOF sample is 0, go to DATA with stuff count=1 and last=0. If the SOF sample is 1, treat it as a glitch and return to IDLE with no error.
  - DATA: shift in 8 non-stuff bits and update the CRC each bit, then go to CRC.
  - CRC: shift in 8 received CRC bits, then go to CRC_DELIM.
  - CRC_DELIM: a sample of 0 is a form error. If received CRC != computed CRC, raise a CRC error and do not ACK. Otherwise go to ACK_SLOT.
  - ACK_SLOT: can_tx=0 from the clk after the CRC_DELIM sample strobe, for exactly CLKS_PER_BIT clk. The sample value is ignored.
  - ACK_DELIM: a sample of 0 is a form error.
  - EOF: 7 samples, all of which must be 1; any 0 is a form error. After the 7th sample, update data_out and pulse rx_valid on the next clk, then go to IDLE.
  - WAIT_IDLE: entered on any error. Wait for 11 consecutive recessive samples, then go to IDLE. can_tx=1 throughout.
- Destuffing (DATA and CRC, counting from SOF):
  - Track the run length of identical bits.
  - After 5 identical bits, the next sampled bit is a stuff bit. It must be the complement, is discarded, and restarts the run at 1 with its own value.
  - A stuff bit equal to the run value is a stuff error.
  - The stuff bit following the 5th run bit is checked even when it falls after CRC[0].
- CRC-8: polynomial 0x07, init 0x00, computed MSB-first over the 8 data bits only.
- Error reporting: rx_err and err_code are presented one clk after the offending sample strobe.
  - Only the first error in a frame is reported.
  - data_out is not changed on error.
- rx_valid and rx_err never assert in the same cycle.

Decomposition:
- Package can_pkg holds:
  - the state enum (IDLE, DATA, CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF, WAIT_IDLE);
  - CRC_POLY=8'h07, STUFF_LEN=5, EOF_LEN=7, IDLE_LEN=11;
  - ERR_STUFF, ERR_CRC, ERR_FORM codes.
- One sub-module, can_bit_timing: synchroniser, phase counter, hard sync/resync, sample strobe, and sampled bit output. The FSM, destuffer and CRC stay in can_receiver.

Test Plan:
- Good frame 0xA5 (CRC 0x72, no stuff bits), CLKS_PER_BIT=10 → can_tx=0 for exactly 10 clk in the ACK slot; rx_valid pulse; data_out=0xA5; rx_err never asserts.
- Good frame 0x3C (CRC 0xB4) sent immediately after the 0xA5 frame → data_out=0x3C; two rx_valid pulses in total.
- Data 0x00 (CRC 0x00; 17 zeros stuffed to 00000 1 00000 1 00000 1 00) → data_out=0x00 and rx_valid pulse. Flipping the first stuff bit to 0 → rx_err with err_code=01 and no ACK.
- Frame 0xA5 with a corrupted CRC (0x73) → no ACK (can_tx stays 1); rx_err with err_code=10; data_out keeps its previous value; after 11 recessive bits, the next good frame is accepted.
- Form errors: CRC delimiter driven 0 → err_code=11. In a separate frame, 3rd EOF bit driven 0 → err_code=11 and no rx_valid.
- Boundary cases:
  - 3-clk dominant glitch in IDLE → no error and state stays IDLE.
  - reset asserted mid-DATA → all outputs return to reset values immediately; a following good frame is received correctly.
